// File: rtl/cam_capture_rgb444.sv
// -----------------------------------------------------------------------------
// cam_capture_rgb444
//
// Camera capture front end for a QQVGA (160x120) frame buffer. It samples the
// camera's RGB565 byte stream (two bytes per pixel) on the pixel clock,
// converts each pixel to RGB444, and issues one write per pixel into the
// buffer's write port. A frame-level FSM aligns capture to VSYNC, clips every
// frame to the H_PIX x V_LIN window and pulses `done` at the end of each
// captured frame.
//
// Optional feature macro: CAM_TESTPATTERN_EN
//   When defined, px_data is ignored and each pixel is an 8-bar colour pattern
//   selected from the horizontal position. Timing, FSM and addressing are
//   unchanged.
//
// Ports:
//   clk_w        in   camera pixel clock, also the buffer write clock
//   reset        in   asynchronous active-high reset
//   init         in   level; 1 = capture frames continuously,
//                     0 = stop after the current frame
//   vsync        in   camera VSYNC (high between frames)
//   href         in   camera HREF (high while line bytes are valid)
//   px_data      in   camera byte bus
//   mem_px_addr  out  buffer write address
//   mem_px_data  out  RGB444 pixel for the buffer
//   px_wr        out  one-cycle write strobe
//   done         out  one-cycle pulse at the end of each captured frame
//   busy         out  high while waiting for a frame or capturing
// -----------------------------------------------------------------------------
module cam_capture_rgb444 #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int H_PIX = 160,
  parameter int V_LIN = 120
) (
  input  logic          clk_w,
  input  logic          reset,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          done,
  output logic          busy
);

  // Counters saturate at the window size, so one extra code is needed.
  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LIN + 1);

  localparam logic [XW-1:0] X_LIM     = XW'(H_PIX);
  localparam logic [YW-1:0] Y_LIM     = YW'(V_LIN);
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_PIX * V_LIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic          phase_q, phase_d;
  // First byte of a pixel; bit 3 (lowest red bit) is never used, so only
  // {byte1[7:4], byte1[2:0]} is kept.
  logic [6:0]    byte1_q, byte1_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [11:0]   pixel;

`ifdef CAM_TESTPATTERN_EN
  // Eight equal-width vertical bars across the line.
  localparam logic [XW-1:0] BAR_W = XW'(H_PIX / 8);
  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'(x_q / BAR_W);
    pixel   = 12'h000;
    case (bar_idx)
      3'd0:    pixel = 12'hFFF;
      3'd1:    pixel = 12'hFF0;
      3'd2:    pixel = 12'h0FF;
      3'd3:    pixel = 12'h0F0;
      3'd4:    pixel = 12'hF0F;
      3'd5:    pixel = 12'hF00;
      3'd6:    pixel = 12'h00F;
      default: pixel = 12'h000;
    endcase
  end
`else
  // RGB565 -> RGB444: R = b1[7:4], G = {b1[2:0], b2[7]}, B = b2[4:1].
  // byte2 is taken straight from the bus in the cycle it is sampled.
  always_comb begin
    pixel = {byte1_q[6:3], byte1_q[2:0], px_data[7], px_data[4:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    vsync_d = vsync;
    href_d  = href;
    phase_d = phase_q;
    byte1_d = byte1_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_q != ST_IDLE);

    // The address advances once the buffer has taken the current write,
    // and parks on the last window location so it can never run past it.
    if (wr_q && (addr_q != ADDR_LAST)) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (init) begin
          state_d = ST_WAIT_FRAME;
        end
      end

      ST_WAIT_FRAME: begin
        // A high->low VSYNC transition marks the start of a fresh frame.
        if (vsync_q && !vsync) begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (vsync && !vsync_q) begin
          // Frame end (also taken mid-line): any half pixel is dropped.
          done_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          phase_d = 1'b0;
          state_d = init ? ST_WAIT_FRAME : ST_IDLE;
        end else if (href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            byte1_d = {px_data[7:4], px_data[2:0]};
          end else begin
            if ((x_q < X_LIM) && (y_q < Y_LIM)) begin
              wr_d   = 1'b1;
              data_d = DW'(pixel);
            end
            if (x_q < X_LIM) begin
              x_d = x_q + 1'b1;
            end
          end
        end else if (href_q) begin
          // Line end: realign the byte phase and move to the next line
          // only if this line produced at least one pixel.
          phase_d = 1'b0;
          x_d     = '0;
          if ((x_q != '0) && (y_q < Y_LIM)) begin
            y_d = y_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_w or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      byte1_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      phase_q <= phase_d;
      byte1_q <= byte1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule
